// File: rtl/bpred_btb.sv
// rtl/bpred_btb.sv - branch target buffer with 2-bit direction counters and prediction statistics
module bpred_btb #(
  parameter int          XLEN     = 32,
  parameter int          ENTRIES  = 16,
  parameter int          TAG_W    = 8,
  parameter logic [1:0]  CNT_INIT = 2'b01,
  parameter int          STAT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   pcF,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [XLEN-1:0]   pred_target,
  input  logic              upd_valid,
  input  logic [XLEN-1:0]   upd_pc,
  input  logic              upd_is_branch,
  input  logic              upd_is_jump,
  input  logic              upd_taken,
  input  logic [XLEN-1:0]   upd_target,
  input  logic              upd_pred_taken,
  input  logic [XLEN-1:0]   upd_pred_target,
  output logic              mispredict,
  input  logic              flush_all,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispred
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic              validQ [ENTRIES];
  logic [TAG_W-1:0]  tagQ   [ENTRIES];
  logic [XLEN-1:0]   tgtQ   [ENTRIES];
  logic              jumpQ  [ENTRIES];
  logic [1:0]        cntQ   [ENTRIES];

  logic [IDX_W-1:0]  fIdx;
  logic [TAG_W-1:0]  fTag;
  logic [IDX_W-1:0]  uIdx;
  logic [TAG_W-1:0]  uTag;
  logic              uHit;
  logic              trainEv;
  logic [1:0]        cntInc;
  logic [1:0]        cntDec;
  logic              unusedPcBits;

  assign fIdx = pcF[IDX_W+1:2];
  assign fTag = pcF[IDX_W+TAG_W+1:IDX_W+2];
  assign uIdx = upd_pc[IDX_W+1:2];
  assign uTag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

  // Bits outside index/tag fields deliberately do not participate (aliasing allowed)
  assign unusedPcBits = ^{pcF, upd_pc};

  // Zero-latency fetch lookup; reads the table as it stood before this edge's write
  always_comb begin
    pred_hit    = validQ[fIdx] && (tagQ[fIdx] == fTag);
    pred_taken  = pred_hit && (jumpQ[fIdx] || cntQ[fIdx][1]);
    pred_target = pred_hit ? tgtQ[fIdx] : '0;
  end

  // Resolution-side decode: training qualifier, redirect, and saturated counter steps
  always_comb begin
    trainEv    = upd_valid && (upd_is_branch || upd_is_jump);
    uHit       = validQ[uIdx] && (tagQ[uIdx] == uTag);
    mispredict = trainEv && ((upd_taken != upd_pred_taken) ||
                             (upd_taken && (upd_target != upd_pred_target)));
    cntInc     = (cntQ[uIdx] == 2'b11) ? 2'b11 : cntQ[uIdx] + 2'b01;
    cntDec     = (cntQ[uIdx] == 2'b00) ? 2'b00 : cntQ[uIdx] - 2'b01;
  end

  // Table training; fence.i flush wins over a same-cycle training write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        validQ[i] <= 1'b0;
        tagQ[i]   <= '0;
        tgtQ[i]   <= '0;
        jumpQ[i]  <= 1'b0;
        cntQ[i]   <= CNT_INIT;
      end
    end else if (flush_all) begin
      for (int i = 0; i < ENTRIES; i++) begin
        validQ[i] <= 1'b0;
      end
    end else if (trainEv) begin
      if (uHit) begin
        if (upd_is_jump) begin
          jumpQ[uIdx] <= 1'b1;
          tgtQ[uIdx]  <= upd_target;
          cntQ[uIdx]  <= 2'b11;
        end else if (upd_taken) begin
          cntQ[uIdx]  <= cntInc;
          tgtQ[uIdx]  <= upd_target;
        end else begin
          cntQ[uIdx]  <= cntDec;
        end
      end else if (upd_taken) begin
        validQ[uIdx] <= 1'b1;
        tagQ[uIdx]   <= uTag;
        tgtQ[uIdx]   <= upd_target;
        jumpQ[uIdx]  <= upd_is_jump;
        cntQ[uIdx]   <= upd_is_jump ? 2'b11 : 2'b10;
      end
    end
  end

  // Saturating performance counters; unaffected by flush
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else begin
      if (trainEv && (stat_branches != '1)) begin
        stat_branches <= stat_branches + STAT_W'(1);
      end
      if (mispredict && (stat_mispred != '1)) begin
        stat_mispred <= stat_mispred + STAT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bpred_btb.sv
// tb/tb_bpred_btb.sv - directed vector bench for bpred_btb
module tb_bpred_btb;

  logic        clk;
  logic        reset;
  logic [31:0] pcF;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_is_branch;
  logic        upd_is_jump;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        flush_all;

  logic        pred_hit, pred_taken, mispredict;
  logic [31:0] pred_target;
  logic [31:0] stat_branches, stat_mispred;

  logic        hit4, taken4, misp4;
  logic [31:0] target4;
  logic [3:0]  statBr4, statMis4;

  int checks = 0;
  int errors = 0;
  int modelBr = 0;
  int modelMis = 0;

  bpred_btb dut (
    .clk(clk), .reset(reset), .pcF(pcF),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch),
    .upd_is_jump(upd_is_jump), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(mispredict), .flush_all(flush_all),
    .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  bpred_btb #(.STAT_W(4)) dut4 (
    .clk(clk), .reset(reset), .pcF(pcF),
    .pred_hit(hit4), .pred_taken(taken4), .pred_target(target4),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch),
    .upd_is_jump(upd_is_jump), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(misp4), .flush_all(flush_all),
    .stat_branches(statBr4), .stat_mispred(statMis4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic        isBr;
    logic        isJmp;
    logic        taken;
    logic [31:0] target;
    logic        predTaken;
    logic [31:0] predTarget;
    logic        expMisp;
    logic [31:0] lookPc;
    logic        expHit;
    logic        expTaken;
    logic [31:0] expTarget;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic br, input logic jmp,
                       input logic tk, input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    upd_valid = v; upd_pc = pc; upd_is_branch = br; upd_is_jump = jmp;
    upd_taken = tk; upd_target = tgt; upd_pred_taken = ptk; upd_pred_target = ptgt;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic checkLook(input string name, input logic [31:0] pc, input logic h,
                           input logic t, input logic [31:0] tg);
    pcF = pc;
    #1;
    check({name, "_hit"}, pred_hit, h);
    check({name, "_taken"}, pred_taken, t);
    check({name, "_target"}, pred_target, tg);
  endtask

  initial begin
    //          valid pc       br   jmp  tk   target   ptk  ptarget  misp look     hit  tk   target
    vecs[0]  = '{1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h80,  1'b0, 32'h0,   1'b1, 32'h100, 1'b1, 1'b1, 32'h80};
    vecs[1]  = '{1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h80,  1'b1, 32'h100, 1'b1, 1'b0, 32'h80};
    vecs[2]  = '{1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h100, 1'b1, 1'b0, 32'h80};
    vecs[3]  = '{1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h100, 1'b1, 1'b0, 32'h80};
    vecs[4]  = '{1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h80,  1'b0, 32'h0,   1'b1, 32'h100, 1'b1, 1'b0, 32'h80};
    vecs[5]  = '{1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h80,  1'b0, 32'h0,   1'b1, 32'h100, 1'b1, 1'b1, 32'h80};
    vecs[6]  = '{1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h80,  1'b1, 32'h80,  1'b0, 32'h100, 1'b1, 1'b1, 32'h80};
    vecs[7]  = '{1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h84,  1'b1, 32'h80,  1'b1, 32'h100, 1'b1, 1'b1, 32'h84};
    vecs[8]  = '{1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h84,  1'b1, 32'h100, 1'b1, 1'b1, 32'h84};
    vecs[9]  = '{1'b0, 32'h100, 1'b1, 1'b0, 1'b1, 32'h90,  1'b0, 32'h0,   1'b0, 32'h140, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 32'h140, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h100, 1'b1, 1'b1, 32'h84};
    vecs[11] = '{1'b1, 32'h140, 1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 1'b0, 32'h0};
    vecs[12] = '{1'b0, 32'h100, 1'b0, 1'b1, 1'b1, 32'h500, 1'b0, 32'h0,   1'b0, 32'h140, 1'b1, 1'b1, 32'h200};
    vecs[13] = '{1'b1, 32'h140, 1'b0, 1'b1, 1'b1, 32'h204, 1'b1, 32'h200, 1'b1, 32'h140, 1'b1, 1'b1, 32'h204};
    vecs[14] = '{1'b1, 32'h104, 1'b1, 1'b1, 1'b1, 32'h300, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 1'b1, 32'h300};
    vecs[15] = '{1'b1, 32'h104, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h300, 1'b1, 32'h104, 1'b1, 1'b1, 32'h300};
    vecs[16] = '{1'b1, 32'h104, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h300, 1'b1, 32'h104, 1'b1, 1'b1, 32'h300};

    reset = 1'b0;
    flush_all = 1'b0;
    pcF = 32'h100;
    idle();
    #1;
    check("rst_hit", pred_hit, 1'b0);
    check("rst_taken", pred_taken, 1'b0);
    check("rst_target", pred_target, 32'h0);
    check("rst_stat_br", stat_branches, 32'h0);
    check("rst_stat_mis", stat_mispred, 32'h0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    checkLook("post_rst", 32'h100, 1'b0, 1'b0, 32'h0);

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].valid, vecs[i].pc, vecs[i].isBr, vecs[i].isJmp, vecs[i].taken,
            vecs[i].target, vecs[i].predTaken, vecs[i].predTarget);
      #1;
      check($sformatf("v%0d_misp", i), mispredict, vecs[i].expMisp);
      if (vecs[i].valid && (vecs[i].isBr || vecs[i].isJmp)) modelBr++;
      if (vecs[i].expMisp) modelMis++;
      tick();
      idle();
      checkLook($sformatf("v%0d", i), vecs[i].lookPc, vecs[i].expHit,
                vecs[i].expTaken, vecs[i].expTarget);
      check($sformatf("v%0d_stat_br", i), stat_branches, 32'(modelBr));
      check($sformatf("v%0d_stat_mis", i), stat_mispred, 32'(modelMis));
    end

    // Same-cycle lookup and allocating update: lookup sees the old (empty) entry
    pcF = 32'h108;
    drive(1'b1, 32'h108, 1'b1, 1'b0, 1'b1, 32'h600, 1'b1, 32'h600);
    #1;
    check("same_cyc_pre_hit", pred_hit, 1'b0);
    check("same_cyc_misp", mispredict, 1'b0);
    modelBr++;
    tick();
    idle();
    checkLook("same_cyc_post", 32'h108, 1'b1, 1'b1, 32'h600);

    // flush_all with a same-cycle taken update: write dropped, stats still counted
    flush_all = 1'b1;
    drive(1'b1, 32'h180, 1'b1, 1'b0, 1'b1, 32'h400, 1'b0, 32'h0);
    modelBr++;
    modelMis++;
    tick();
    flush_all = 1'b0;
    idle();
    checkLook("flush_180", 32'h180, 1'b0, 1'b0, 32'h0);
    checkLook("flush_140", 32'h140, 1'b0, 1'b0, 32'h0);
    checkLook("flush_104", 32'h104, 1'b0, 1'b0, 32'h0);
    checkLook("flush_108", 32'h108, 1'b0, 1'b0, 32'h0);
    check("flush_stat_br", stat_branches, 32'(modelBr));
    check("flush_stat_mis", stat_mispred, 32'(modelMis));

    // 20 mispredicted updates: 4-bit statistics must stick at 15
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'h10C, 1'b1, 1'b0, 1'b1, 32'h700, 1'b0, 32'h0);
      modelBr++;
      modelMis++;
      tick();
    end
    idle();
    #1;
    check("sat_stat_br4", statBr4, 4'hF);
    check("sat_stat_mis4", statMis4, 4'hF);
    check("sat_stat_br32", stat_branches, 32'(modelBr));
    check("sat_stat_mis32", stat_mispred, 32'(modelMis));
    checkLook("pre_areset", 32'h10C, 1'b1, 1'b1, 32'h700);

    // Asynchronous reset mid-cycle with an update in flight
    @(posedge clk);
    #3;
    drive(1'b1, 32'h10C, 1'b1, 1'b0, 1'b1, 32'h700, 1'b0, 32'h0);
    reset = 1'b0;
    #1;
    check("areset_hit", pred_hit, 1'b0);
    check("areset_taken", pred_taken, 1'b0);
    check("areset_target", pred_target, 32'h0);
    check("areset_stat_br", stat_branches, 32'h0);
    check("areset_stat_mis", stat_mispred, 32'h0);
    check("areset_stat_br4", statBr4, 4'h0);
    check("areset_stat_mis4", statMis4, 4'h0);
    check("areset_misp_follows", mispredict, 1'b1);
    tick();
    check("areset_held_hit", pred_hit, 1'b0);
    reset = 1'b1;
    idle();
    checkLook("after_rel", 32'h10C, 1'b0, 1'b0, 32'h0);
    // First training after release is a not-taken miss: table must stay empty
    drive(1'b1, 32'h10C, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    idle();
    checkLook("first_train", 32'h10C, 1'b0, 1'b0, 32'h0);
    check("first_train_stat_br", stat_branches, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bpred_btb.md
Name: bpred_btb

Overview:
Parametrised branch target buffer with a 2-bit saturating direction predictor for the 5-stage xgriscv pipeline. It sits beside the fetch-stage PC register. It gives a same-cycle taken/target prediction for pcF and is trained by the resolved branch/jump outcome from the decode stage. It replaces the fixed predict-not-taken policy, cutting flushD bubbles. It also keeps saturating prediction statistics for performance counters.

Parameters:
XLEN, 32, PC and target width
ENTRIES, 16, table depth; power of two, >= 2; IDX_W = clog2(ENTRIES)
TAG_W, 8, stored tag bits; IDX_W + TAG_W + 2 <= XLEN
CNT_INIT, 2'b01, counter value at reset (weakly not-taken)
STAT_W, 32, width of statistics counters

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
pcF  input  XLEN  fetch PC to predict
pred_hit  output  1  valid entry with matching tag for pcF
pred_taken  output  1  predict taken
pred_target  output  XLEN  predicted next PC (valid when pred_taken)
upd_valid  input  1  decode-stage resolution valid this cycle
upd_pc  input  XLEN  PC of resolved instruction (pcD)
upd_is_branch  input  1  conditional branch
upd_is_jump  input  1  jal/jalr
upd_taken  input  1  actual outcome (1 for jumps)
upd_target  input  XLEN  actual target (pcbranchD)
upd_pred_taken  input  1  prediction made at fetch, carried down the pipe
upd_pred_target  input  XLEN  predicted target, carried down the pipe
mispredict  output  1  redirect required
flush_all  input  1  invalidate every entry (fence.i)
stat_branches  output  STAT_W  resolved branch/jump count
stat_mispred  output  STAT_W  mispredict count

Behaviour:
- Index = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2]. Per entry: valid, tag, target[XLEN-1:0], jump bit, cnt[1:0].
- Lookup is combinational from pcF (zero latency). pred_hit = valid & tag match. pred_taken = pred_hit & (jump | cnt[1]). pred_target = entry target when pred_hit, else 0.
- mispredict is combinational: upd_valid & (upd_is_branch|upd_is_jump) & ((upd_taken != upd_pred_taken) | (upd_taken & upd_target != upd_pred_target)). It is 0 when upd_valid=0.
- Training happens on the rising edge when upd_valid & (upd_is_branch|upd_is_jump). upd_is_branch and upd_is_jump are never both 1; if both are, jump wins.
- Hit, conditional branch: cnt saturating +1 if taken, -1 if not taken (3 stays 3, 0 stays 0). If taken, target <= upd_target.
- Hit, jump: jump <= 1, target <= upd_target, cnt <= 2'b11.
- Miss and taken: allocate (overwrite) the indexed entry. valid=1, tag, target=upd_target, jump=upd_is_jump, cnt = jump ? 2'b11 : 2'b10.
- Miss and not taken: no table change.
- Same-cycle lookup and update of the same entry: the lookup returns the pre-update contents. There is no write-to-read bypass.
- flush_all: all valid <= 0 at the edge. It takes priority over a same-cycle training write, which is dropped. Statistics still count that update.
- Statistics: stat_branches += 1 per training event. stat_mispred += 1 when mispredict=1. Both saturate at all-ones. flush_all does not clear them.
- Reset (asynchronous, active-low): all valid=0, cnt=CNT_INIT, targets/tags/jump=0, statistics=0. Consequently pred_hit=0, pred_taken=0, pred_target=0. mispredict follows its inputs.
- Reset asserted mid-operation overrides any in-flight update. The first training edge after reset release behaves as on an empty table.
- Upper pc bits above the tag are not compared, so aliasing is permitted. Bits [1:0] are ignored.

Test Plan:
- Reset released, pcF=0x100 → pred_hit=0, pred_taken=0, pred_target=0. stat_branches=0, stat_mispred=0.
- Update pc=0x100, branch, taken, target=0x80, pred_taken=0 → mispredict=1 that cycle. Next cycle pcF=0x100 gives hit=1, taken=1, target=0x80, cnt=2. stat_mispred=1.
- Counter saturation at 0x100: two not-taken updates → cnt=0, pred_taken=0. A third not-taken keeps cnt=0. Three taken updates → cnt=3; a fourth taken keeps cnt=3.
- Aliasing (ENTRIES=16): entry holds 0x100. pcF=0x140 (same index, different tag) → hit=0. A not-taken update at 0x140 leaves 0x100 intact. A taken jal update at 0x140 (target 0x200) replaces it, so 0x100 misses and 0x140 predicts 0x200.
- flush_all and a taken update at 0x180 in the same cycle → next cycle every pcF misses, including 0x180. stat_branches still increments.
- STAT_W=4: 20 mispredicted updates → both stats stay at 15. Then async reset pulse mid-cycle → outputs zero immediately, table empty after release.
